mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester page-memory arbiter with round-robin grants and prioritised
// memory load/save strobes; one registered decision per clock.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] page0,
    input  logic [ADDR_W-1:0] page1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    input  logic              load_req,
    input  logic              save_req,
    output logic              busy,
    output logic              mem_write,
    output logic              mem_load,
    output logic              mem_save,
    output logic [ADDR_W-1:0] mem_page,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester holds req/wr/page/wdata stable until it sees its
    // one-cycle gnt; the request is consumed at the edge that ends that cycle.
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_LOAD, ST_SAVE} state_t;

    state_t              state_q, state_d;
    logic                gid_q, gid_d;
    logic                last_q, last_d;
    logic                load_pend_q, load_pend_d;
    logic                save_pend_q, save_pend_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   page_q, page_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rvalid_q, rvalid_d;
    logic                rid_q, rid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                elig0, elig1, pick1;

    assign gnt0      = (state_q == ST_ACCESS) & ~gid_q;
    assign gnt1      = (state_q == ST_ACCESS) &  gid_q;
    assign mem_load  = (state_q == ST_LOAD);
    assign mem_save  = (state_q == ST_SAVE);
    assign mem_write = wr_q;
    assign mem_page  = page_q;
    assign mem_data  = data_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rdata     = rdata_q;
    assign busy      = load_pend_q | save_pend_q | mem_load | mem_save;
    assign state_dbg = state_q;

    assign elig0 = req0 & ~gnt0;
    assign elig1 = req1 & ~gnt1;
    // With both eligible, requester 1 wins only if requester 0 was granted last.
    assign pick1 = elig1 & (~elig0 | ~last_q);

    always_comb begin
        state_d     = ST_IDLE;
        gid_d       = gid_q;
        last_d      = last_q;
        load_pend_d = load_pend_q | load_req;
        save_pend_d = save_pend_q | save_req;
        wr_d        = 1'b0;
        page_d      = page_q;
        data_d      = data_q;
        rvalid_d    = 1'b0;
        rid_d       = rid_q;
        rdata_d     = rdata_q;

        if (load_pend_q) begin
            state_d     = ST_LOAD;
            load_pend_d = 1'b0;
        end else if (save_pend_q) begin
            state_d     = ST_SAVE;
            save_pend_d = 1'b0;
        end else if (elig0 | elig1) begin
            state_d = ST_ACCESS;
            gid_d   = pick1;
            last_d  = pick1;
            wr_d    = pick1 ? wr1 : wr0;
            page_d  = pick1 ? page1 : page0;
            data_d  = pick1 ? wdata1 : wdata0;
        end

        if (state_q == ST_ACCESS && !wr_q) begin
            rvalid_d = 1'b1;
            rid_d    = gid_q;
            rdata_d  = mem_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gid_q       <= 1'b0;
            last_q      <= 1'b1;
            load_pend_q <= 1'b0;
            save_pend_q <= 1'b0;
            wr_q        <= 1'b0;
            page_q      <= '0;
            data_q      <= '0;
            rvalid_q    <= 1'b0;
            rid_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gid_q       <= gid_d;
            last_q      <= last_d;
            load_pend_q <= load_pend_d;
            save_pend_q <= save_pend_d;
            wr_q        <= wr_d;
            page_q      <= page_d;
            data_q      <= data_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural page memory, directed and random accesses,
// read results scoreboarded through an expected queue.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 25;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] page0 = '0, page1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid, rid;
  logic [DW-1:0] rdata;
  logic          load_req = 0, save_req = 0;
  logic          busy, mem_write, mem_load, mem_save;
  logic [AW-1:0] mem_page;
  logic [DW-1:0] mem_data, mem_out;
  logic [1:0]    state_dbg;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] model [64];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_item;
  int            n_vec = 0;
  int            n_err = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .page0(page0), .page1(page1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid), .rdata(rdata),
    .load_req(load_req), .save_req(save_req), .busy(busy),
    .mem_write(mem_write), .mem_load(mem_load), .mem_save(mem_save),
    .mem_page(mem_page), .mem_data(mem_data), .mem_out(mem_out),
    .state_dbg(state_dbg)
  );

  // clock / memory
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_page] <= mem_data;
  end
  assign mem_out = mem[mem_page];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard and invariants
  always @(negedge clk) begin
    if (rvalid) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
      else begin
        exp_item = exp_q.pop_front();
        check("read_result", {rid, rdata}, exp_item);
      end
    end
    if (gnt0 | gnt1 | mem_load | mem_save)
      check("strobe_onehot", W'($countones({gnt0, gnt1, mem_load, mem_save})), 1);
    if (mem_write) check("write_in_gnt", gnt0 | gnt1, 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic id, input logic wr, input logic [AW-1:0] pg,
                           input logic [DW-1:0] d);
    int lat;
    lat = -1;
    if (id) begin req1 = 1; wr1 = wr; page1 = pg; wdata1 = d; end
    else    begin req0 = 1; wr0 = wr; page0 = pg; wdata0 = d; end
    if (wr) model[pg] = d;
    else exp_q.push_back({id, model[pg]});
    for (int i = 0; i < 20; i++) begin
      tick();
      if (id ? gnt1 : gnt0) begin lat = i; break; end
    end
    check("gnt_latency", W'(lat), 0);
    if (lat >= 0) begin
      check("gnt_other", id ? gnt0 : gnt1, 0);
      check("mem_page", W'(mem_page), W'(pg));
      check("mem_write", mem_write, wr);
      if (wr) check("mem_data", W'(mem_data), W'(d));
    end else if (!wr) begin
      void'(exp_q.pop_back());
    end
    req0 = 0; req1 = 0;
    tick();
    check("rvalid_latency", rvalid, (lat >= 0) && !wr);
    check("mem_write_after", mem_write, 0);
  endtask

  initial begin
    logic got;
    // reset and memory preload
    for (int i = 0; i < 64; i++) begin
      pl_en = 1; pl_addr = AW'(i);
      pl_data = (i == 5) ? 25'h1ABCDE : DW'($urandom);
      model[i] = pl_data;
      tick();
    end
    pl_en = 0;
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_rvalid", {rvalid, rid}, 0);
    check("rst_rdata", W'(rdata), 0);
    check("rst_strobes", {mem_write, mem_load, mem_save, busy}, 0);
    check("rst_page_data", W'(mem_page) | W'(mem_data), 0);
    rst_n = 1;
    tick();

    // single read of page 5
    do_access(0, 0, 6'd5, '0);

    // write page 63 then read it back via requester 1
    do_access(1, 1, 6'd63, 25'h0000001);
    do_access(1, 0, 6'd63, '0);

    // contention: both requesters reading continuously
    req0 = 1; wr0 = 0; page0 = 6'd5;
    req1 = 1; wr1 = 0; page1 = 6'd63;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2) ? {1'b1, model[63]} : {1'b0, model[5]});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_gnt0", gnt0, (k % 2) == 0);
      check("cont_gnt1", gnt1, (k % 2) == 1);
    end
    req0 = 0; req1 = 0;
    tick(); tick();

    // random single-requester traffic
    for (int n = 0; n < 10; n++)
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 63)), DW'($urandom));

    // load/save arriving during a gnt0 cycle while req0 stays high
    req0 = 1; wr0 = 1; page0 = 6'd10; wdata0 = DW'($urandom); model[10] = wdata0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = gnt0;
    end
    check("ls_first_gnt", got, 1);
    load_req = 1; save_req = 1;
    tick();
    load_req = 0; save_req = 0;
    check("ls_busy_pend", {busy, gnt0, mem_load, mem_save}, 4'b1000);
    tick();
    check("ls_load", {busy, gnt0, mem_load, mem_save}, 4'b1010);
    tick();
    check("ls_save", {busy, gnt0, mem_load, mem_save}, 4'b1001);
    tick();
    check("ls_gnt_after", {busy, gnt0, mem_load, mem_save}, 4'b0100);
    check("ls_write", mem_write, 1);
    req0 = 0;
    tick();
    check("ls_idle", {busy, mem_write}, 0);

    // repeated load pulse while already pending is absorbed
    load_req = 1;
    tick();
    tick();
    load_req = 0;
    check("absorb_load", {busy, mem_load}, 2'b11);
    tick();
    check("absorb_done", {busy, mem_load}, 0);

    // reset during a gnt1 read cycle
    req1 = 1; wr1 = 0; page1 = 6'd7;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = gnt1;
    end
    check("mid_gnt1", got, 1);
    rst_n = 0;
    #1;
    check("mid_rst_gnt", {gnt0, gnt1, rvalid, rid}, 0);
    check("mid_rst_rdata", W'(rdata), 0);
    check("mid_rst_strobes", {mem_write, mem_load, mem_save, busy}, 0);
    check("mid_rst_page_data", W'(mem_page) | W'(mem_data), 0);
    req0 = 1; wr0 = 0; page0 = 6'd5; page1 = 6'd63;
    tick(); tick();
    check("mid_rst_norvalid", rvalid, 0);
    rst_n = 1;
    exp_q.push_back({1'b0, model[5]});
    exp_q.push_back({1'b1, model[63]});
    tick();
    check("post_rst_first", {gnt0, gnt1}, 2'b10);
    tick();
    check("post_rst_second", {gnt0, gnt1}, 2'b01);
    req0 = 0; req1 = 0;
    repeat (4) tick();
    check("queue_empty", W'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
